// File: rtl/ram_16x8.sv
// SAP-1 16x8 program/data memory: registered read port for the W bus and a
// valid/ready program port; a zeroing sweep runs after every reset.
module ram_16x8 #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic [AW-1:0] ADDR,
  input  logic          CE,
  output logic [DW-1:0] Q,
  output logic          Q_VALID,
  input  logic          PROG,
  input  logic [AW-1:0] PA,
  input  logic [DW-1:0] PD,
  input  logic          PVALID,
  output logic          PREADY,
  output logic          BUSY
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_PGM} state_t;

  state_t          state_q;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   q_q;
  logic            q_valid_q;
  logic [DW-1:0]   mem [2**AW];
  logic            wr_clr, wr_pgm;

  assign cnt_d   = cnt_q + 1'b1;
  assign BUSY    = (state_q == S_INIT);
  assign PREADY  = (state_q == S_PGM) && PROG;
  assign wr_clr  = (state_q == S_INIT);
  assign wr_pgm  = PREADY && PVALID;
  assign Q       = q_q;
  assign Q_VALID = q_valid_q;

  // The array has no reset of its own; CLR only blocks writes on its edge.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      if (wr_clr)      mem[cnt_q] <= '0;
      else if (wr_pgm) mem[PA]    <= PD;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_d;
          // PROG is only looked at on the edge that zeroes the last word.
          if (cnt_q == {AW{1'b1}}) state_q <= PROG ? S_PGM : S_RUN;
        end
        S_RUN: begin
          if (PROG) state_q <= S_PGM;
          else if (CE) begin
            q_q       <= mem[ADDR];
            q_valid_q <= 1'b1;
          end
        end
        S_PGM: begin
          if (!PROG) state_q <= S_RUN;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_16x8.sv
// Self-checking bench for ram_16x8: a reference memory image feeds a
// scoreboard of expected read responses compared cycle by cycle.
module tb_ram_16x8;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [3:0] ADDR = '0;
  logic       CE = 1'b0;
  logic [7:0] Q;
  logic       Q_VALID;
  logic       PROG = 1'b0;
  logic [3:0] PA = '0;
  logic [7:0] PD = '0;
  logic       PVALID = 1'b0;
  logic       PREADY;
  logic       BUSY;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_mem [16];
  int         checks = 0;
  int         failures = 0;

  ram_16x8 dut (
    .CLK(CLK), .CLR(CLR), .ADDR(ADDR), .CE(CE), .Q(Q), .Q_VALID(Q_VALID),
    .PROG(PROG), .PA(PA), .PD(PD), .PVALID(PVALID), .PREADY(PREADY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Push the read response the model predicts for the stimulus now driven.
  task automatic push_exp(input logic ce, input logic [3:0] a);
    exp_t e;
    e.v = ce;
    e.d = ce ? model_mem[a] : 8'h00;
    sb.push_back(e);
  endtask

  task automatic wait_sweep();
    int n = 0;
    while (BUSY === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL sweep_timeout busy=%b after %0d cycles", BUSY, n);
    end
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    PA = a; PD = d; PVALID = 1'b1;
    tick();
    PVALID = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic test_reset();
    int n = 0;
    CLR = 1'b1; CE = 1'b1; PROG = 1'b0;
    tick();
    checks++;
    if (Q !== 8'h00 || Q_VALID !== 1'b0 || PREADY !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs got q=%h v=%b rdy=%b busy=%b want 00 0 0 1",
               Q, Q_VALID, PREADY, BUSY);
    end
    CLR = 1'b0;
    while (BUSY === 1'b1 && n < 40) begin
      n++;
      checks++;
      if (Q_VALID !== 1'b0 || Q !== 8'h00 || PREADY !== 1'b0) begin
        failures++;
        $display("FAIL sweep_quiet got q=%h v=%b rdy=%b want 00 0 0", Q, Q_VALID, PREADY);
      end
      tick();
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL reset_busy_len got %0d want 16", n);
    end
    CE = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
  endtask

  task automatic test_sweep_clears();
    exp_t e;
    PROG = 1'b1;
    tick();
    checks++;
    if (PREADY !== 1'b1 || Q_VALID !== 1'b0) begin
      failures++;
      $display("FAIL enter_pgm got rdy=%b v=%b want 1 0", PREADY, Q_VALID);
    end
    for (int i = 0; i < 16; i++) prog_write(i[3:0], 8'hFF);
    PROG = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      ADDR = 4'(i * 7); CE = 1'b1;
      push_exp(1'b1, ADDR);
      tick();
      e = sb.pop_front();
      checks++;
      if (Q_VALID !== e.v || Q !== e.d) begin
        failures++;
        $display("FAIL prefill_read a=%0d got %b/%h want %b/%h", i * 7, Q_VALID, Q, e.v, e.d);
      end
    end
    CE = 1'b0; CLR = 1'b1;
    tick();
    CLR = 1'b0;
    wait_sweep();
    for (int i = 0; i < 16; i++) begin
      ADDR = i[3:0]; CE = 1'b1;
      push_exp(1'b1, ADDR);
      tick();
      e = sb.pop_front();
      checks++;
      if (Q_VALID !== e.v || Q !== e.d) begin
        failures++;
        $display("FAIL cleared_read a=%0d got %b/%h want %b/%h", i, Q_VALID, Q, e.v, e.d);
      end
    end
    CE = 1'b0;
  endtask

  task automatic test_mode_exit();
    exp_t e;
    PROG = 1'b1;
    tick();
    PA = 4'd5; PD = 8'h77; PVALID = 1'b1; PROG = 1'b0;
    #1;
    checks++;
    if (PREADY !== 1'b0) begin
      failures++;
      $display("FAIL exit_pready got %b want 0", PREADY);
    end
    tick();
    PVALID = 1'b0;
    ADDR = 4'd5; CE = 1'b1;
    push_exp(1'b1, ADDR);
    tick();
    e = sb.pop_front();
    checks++;
    if (Q_VALID !== e.v || Q !== e.d) begin
      failures++;
      $display("FAIL exit_nowrite got %b/%h want %b/%h", Q_VALID, Q, e.v, e.d);
    end
    CE = 1'b0;
  endtask

  task automatic test_program_run();
    exp_t e;
    logic [3:0] a [3] = '{4'd3, 4'd15, 4'd3};
    logic       c [3] = '{1'b1, 1'b1, 1'b0};
    PROG = 1'b1; CE = 1'b1; ADDR = 4'd3;
    tick();
    checks++;
    if (Q_VALID !== 1'b0 || Q !== 8'h00) begin
      failures++;
      $display("FAIL pgm_entry_noread got %b/%h want 0/00", Q_VALID, Q);
    end
    PA = 4'd3; PD = 8'h2A; PVALID = 1'b1;
    #1;
    checks++;
    if (PREADY !== 1'b1) begin
      failures++;
      $display("FAIL pgm_pready got %b want 1", PREADY);
    end
    tick();
    model_mem[3] = 8'h2A;
    PA = 4'd15; PD = 8'hC5;
    tick();
    model_mem[15] = 8'hC5;
    checks++;
    if (Q_VALID !== 1'b0) begin
      failures++;
      $display("FAIL pgm_ce_ignored got v=%b want 0", Q_VALID);
    end
    PVALID = 1'b0; PROG = 1'b0; CE = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      ADDR = a[i]; CE = c[i];
      push_exp(c[i], a[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (Q_VALID !== e.v || Q !== e.d) begin
        failures++;
        $display("FAIL prog_readback step=%0d got %b/%h want %b/%h", i, Q_VALID, Q, e.v, e.d);
      end
    end
    CE = 1'b0;
  endtask

  task automatic test_ce_gating();
    exp_t e;
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      ADDR = i[3:0]; CE = (i == 3);
      push_exp(CE, ADDR);
      tick();
      e = sb.pop_front();
      if (Q_VALID === 1'b1) pulses++;
      checks++;
      if (Q_VALID !== e.v || Q !== e.d) begin
        failures++;
        $display("FAIL ce_gating step=%0d got %b/%h want %b/%h", i, Q_VALID, Q, e.v, e.d);
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL ce_pulse_count got %0d want 1", pulses);
    end
    CE = 1'b0;
  endtask

  task automatic test_mar_stream();
    exp_t e;
    int win [2] = '{0, 0};
    PROG = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) prog_write(i[3:0], 8'(8'h10 + i * 13));
    PROG = 1'b0;
    tick();
    for (int i = 0; i < 18; i++) begin
      ADDR = 4'(i + 2); CE = ((i % 9) < 3);
      push_exp(CE, ADDR);
      tick();
      e = sb.pop_front();
      if (Q_VALID === 1'b1) win[i / 9]++;
      checks++;
      if (Q_VALID !== e.v || Q !== e.d) begin
        failures++;
        $display("FAIL mar_stream step=%0d got %b/%h want %b/%h", i, Q_VALID, Q, e.v, e.d);
      end
    end
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (win[w] != 3) begin
        failures++;
        $display("FAIL mar_window w=%0d got %0d want 3", w, win[w]);
      end
    end
    CE = 1'b0;
  endtask

  task automatic test_clr_mid();
    exp_t e;
    int n = 0;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    CLR = 1'b1; PROG = 1'b1;
    tick();
    CLR = 1'b0;
    while (BUSY === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL clr_restart_len got %0d want 16", n);
    end
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    checks++;
    if (PREADY !== 1'b1) begin
      failures++;
      $display("FAIL exit_to_pgm got rdy=%b want 1", PREADY);
    end
    prog_write(4'd9, 8'h55);
    PA = 4'd9; PD = 8'h99; PVALID = 1'b1; CLR = 1'b1;
    tick();
    checks++;
    if (BUSY !== 1'b1 || PREADY !== 1'b0) begin
      failures++;
      $display("FAIL clr_in_pgm got busy=%b rdy=%b want 1 0", BUSY, PREADY);
    end
    CLR = 1'b0; PVALID = 1'b0; PROG = 1'b0;
    wait_sweep();
    for (int i = 0; i < 2; i++) begin
      ADDR = (i == 0) ? 4'd9 : 4'd15; CE = 1'b1;
      push_exp(1'b1, ADDR);
      tick();
      e = sb.pop_front();
      checks++;
      if (Q_VALID !== e.v || Q !== e.d) begin
        failures++;
        $display("FAIL clr_mid_read a=%0d got %b/%h want %b/%h", ADDR, Q_VALID, Q, e.v, e.d);
      end
    end
    CE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep_clears();
    test_mode_exit();
    test_program_run();
    test_ce_gating();
    test_mar_stream();
    test_clr_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
